// File: rtl/output_controller_if.sv
// Command channel from the calculator core to the output controller.
// A command transfers on a rising edge where cmd_valid and cmd_ready are both high.
interface output_controller_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/output_controller.sv
// Display/LED/buzzer sequencer: executes one-word commands, drives four segment octets
// (bit 7 = segment a ... bit 1 = segment g, bit 0 = dp), handles blinking and beep trains.
module output_controller #(
   parameter int BEEP_CYC  = 5000000,
   parameter int BLINK_CYC = 12500000
) (
   input  logic                Clock,
   input  logic                Reset,
   output_controller_if.slave  cmd,
   output logic [7:0]          oct0,
   output logic [7:0]          oct1,
   output logic [7:0]          oct2,
   output logic [7:0]          oct3,
   output logic [7:0]          LD,
   output logic                Buzz,
   output logic                busy,
   output logic [1:0]          dbg_state
);

   localparam int BEEP_W  = $clog2(BEEP_CYC);
   localparam int BLINK_W = $clog2(BLINK_CYC);
   localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEP_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   typedef enum logic [1:0] {IDLE, EXEC, BEEP_ON, BEEP_OFF} state_e;
   typedef enum logic [2:0] {OP_NOP, OP_HEX, OP_LED, OP_BEEP,
                             OP_BLINK, OP_CLEAR, OP_DP, OP_ERR} op_e;

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [15:0]          data_q, data_d;
   logic [3:0][6:0]      seg_q, seg_d;
   logic [3:0]           dp_q, dp_d;
   logic [7:0]           ld_q, ld_d;
   logic [7:0]           beeps_q, beeps_d;
   logic [BEEP_W-1:0]    beep_cnt_q, beep_cnt_d;
   logic                 blink_en_q, blink_en_d;
   logic                 blink_ph_q, blink_ph_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 buzz_q, buzz_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic [3:0][7:0]      oct_q, oct_d;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'h7E;  4'h1: hex_font = 7'h30;
         4'h2: hex_font = 7'h6D;  4'h3: hex_font = 7'h79;
         4'h4: hex_font = 7'h33;  4'h5: hex_font = 7'h5B;
         4'h6: hex_font = 7'h5F;  4'h7: hex_font = 7'h70;
         4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h7B;
         4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h1F;
         4'hC: hex_font = 7'h4E;  4'hD: hex_font = 7'h3D;
         4'hE: hex_font = 7'h4F;  default: hex_font = 7'h47;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      seg_d       = seg_q;
      dp_d        = dp_q;
      ld_d        = ld_q;
      beeps_d     = beeps_q;
      beep_cnt_d  = beep_cnt_q;
      blink_en_d  = blink_en_q;
      blink_ph_d  = blink_ph_q;
      blink_cnt_d = blink_cnt_q;

      if (blink_en_q) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               op_d    = op_e'(cmd.cmd_op);
               data_d  = cmd.cmd_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = IDLE;
            case (op_q)
               OP_HEX:  for (int i = 0; i < 4; i++) seg_d[i] = hex_font(data_q[4*(3-i) +: 4]);
               OP_LED:  ld_d = data_q[7:0];
               OP_BEEP: begin
                  if (data_q[7:0] != 8'd0) begin
                     beeps_d    = data_q[7:0];
                     beep_cnt_d = '0;
                     state_d    = BEEP_ON;
                  end
               end
               // Restarting the blink always begins with a visible phase.
               OP_BLINK: begin
                  blink_en_d  = data_q[0];
                  blink_cnt_d = '0;
                  blink_ph_d  = 1'b0;
               end
               OP_CLEAR: begin
                  seg_d       = '0;
                  dp_d        = '0;
                  blink_en_d  = 1'b0;
                  blink_cnt_d = '0;
                  blink_ph_d  = 1'b0;
               end
               OP_DP:   for (int i = 0; i < 4; i++) dp_d[i] = data_q[3-i];
               OP_ERR: begin
                  seg_d[0]   = 7'h4F;
                  seg_d[1]   = 7'h05;
                  seg_d[2]   = 7'h05;
                  seg_d[3]   = 7'h00;
                  dp_d       = '0;
                  beeps_d    = 8'd3;
                  beep_cnt_d = '0;
                  state_d    = BEEP_ON;
               end
               default: ;
            endcase
         end
         BEEP_ON: begin
            if (beep_cnt_q == BEEP_LAST) begin
               beep_cnt_d = '0;
               state_d    = BEEP_OFF;
            end else begin
               beep_cnt_d = beep_cnt_q + 1'b1;
            end
         end
         default: begin
            if (beep_cnt_q == BEEP_LAST) begin
               beep_cnt_d = '0;
               if (beeps_q > 8'd1) begin
                  beeps_d = beeps_q - 8'd1;
                  state_d = BEEP_ON;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               beep_cnt_d = beep_cnt_q + 1'b1;
            end
         end
      endcase

      // All visible outputs are registered from the next-state values.
      buzz_d  = (state_d == BEEP_ON);
      busy_d  = (state_d == BEEP_ON) || (state_d == BEEP_OFF);
      ready_d = (state_d == IDLE);
      for (int i = 0; i < 4; i++)
         oct_d[i] = (blink_en_d && blink_ph_d) ? 8'h00 : {seg_d[i], dp_d[i]};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         data_q      <= '0;
         seg_q       <= '0;
         dp_q        <= '0;
         ld_q        <= '0;
         beeps_q     <= '0;
         beep_cnt_q  <= '0;
         blink_en_q  <= 1'b0;
         blink_ph_q  <= 1'b0;
         blink_cnt_q <= '0;
         buzz_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
         oct_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         ld_q        <= ld_d;
         beeps_q     <= beeps_d;
         beep_cnt_q  <= beep_cnt_d;
         blink_en_q  <= blink_en_d;
         blink_ph_q  <= blink_ph_d;
         blink_cnt_q <= blink_cnt_d;
         buzz_q      <= buzz_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         oct_q       <= oct_d;
      end
   end

   assign cmd.cmd_ready = ready_q;
   assign oct0      = oct_q[0];
   assign oct1      = oct_q[1];
   assign oct2      = oct_q[2];
   assign oct3      = oct_q[3];
   assign LD        = ld_q;
   assign Buzz      = buzz_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_output_controller.sv
// Self-checking bench for output_controller: randomized commands against a
// cycle-count based reference of display contents, blink phase and beep trains.
module tb_output_controller;
   localparam int BEEP_CYC  = 4;
   localparam int BLINK_CYC = 3;
   localparam int WAIT_MAX  = 3000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   output_controller_if cif ();
   logic [7:0] oct0, oct1, oct2, oct3, ld;
   logic       buzz, busy;
   logic [1:0] dbg_state;
   logic [7:0] oct_arr [4];

   output_controller #(.BEEP_CYC(BEEP_CYC), .BLINK_CYC(BLINK_CYC)) dut (
      .Clock(clk), .Reset(rst), .cmd(cif),
      .oct0(oct0), .oct1(oct1), .oct2(oct2), .oct3(oct3),
      .LD(ld), .Buzz(buzz), .busy(busy), .dbg_state(dbg_state)
   );

   assign oct_arr[0] = oct0;
   assign oct_arr[1] = oct1;
   assign oct_arr[2] = oct2;
   assign oct_arr[3] = oct3;

   int cyc = 0;
   int buzz_rises = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge buzz) buzz_rises++;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- reference model ----------------
   logic [6:0] font_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   logic [6:0] m_seg [4];
   logic       m_dp  [4];
   logic [7:0] m_ld;
   logic       m_blink_en;
   int         m_blink_edge;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_seg[i] = 7'h00;
         m_dp[i]  = 1'b0;
      end
      m_ld = 8'h00;
      m_blink_en = 1'b0;
      m_blink_edge = 0;
   endfunction

   function automatic void model_cmd(input logic [2:0] op, input logic [15:0] d, input int exec_edge);
      case (op)
         3'd1: for (int i = 0; i < 4; i++) m_seg[i] = font_tab[(d >> (4*(3-i))) & 16'hF];
         3'd2: m_ld = d[7:0];
         3'd4: begin m_blink_en = d[0]; m_blink_edge = exec_edge; end
         3'd5: begin
            for (int i = 0; i < 4; i++) begin m_seg[i] = 7'h00; m_dp[i] = 1'b0; end
            m_blink_en = 1'b0;
         end
         3'd6: for (int i = 0; i < 4; i++) m_dp[i] = d[3-i];
         3'd7: begin
            m_seg[0] = 7'h4F; m_seg[1] = 7'h05; m_seg[2] = 7'h05; m_seg[3] = 7'h00;
            for (int i = 0; i < 4; i++) m_dp[i] = 1'b0;
         end
         default: ;
      endcase
   endfunction

   // Expected octet as seen just after edge number t.
   function automatic logic [7:0] exp_oct(input int i, input int t);
      if (m_blink_en && (((t - m_blink_edge) / BLINK_CYC) % 2 == 1)) return 8'h00;
      return {m_seg[i], m_dp[i]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [15:0] d, output int acc);
      int waited = 0;
      while (cif.cmd_ready !== 1'b1 && waited < WAIT_MAX) begin step(1); waited++; end
      n_chk++;
      if (waited >= WAIT_MAX) $display("FAIL send_wait op=%0d cmd_ready=%b required 1", op, cif.cmd_ready);
      else n_pass++;
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_data  = d;
      step(1);
      acc = cyc;
      cif.cmd_valid = 1'b0;
      model_cmd(op, d, acc + 1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      step(3);
      n_chk += 5;
      if (cif.cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cif.cmd_ready); else n_pass++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      if (buzz !== 1'b0) $display("FAIL reset_buzz got %b want 0", buzz); else n_pass++;
      if (ld !== 8'h00) $display("FAIL reset_ld got %h want 00", ld); else n_pass++;
      if ({oct0, oct1, oct2, oct3} !== 32'h0) $display("FAIL reset_oct got %h%h%h%h want 0", oct0, oct1, oct2, oct3); else n_pass++;
      rst = 1'b0;
      model_reset();
      step(1);
   endtask

   task automatic test_hex_dp();
      int acc;
      logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
      logic [15:0] d;
      logic [2:0] op;
      send_cmd(3'd1, 16'h1A2F, acc);
      n_chk++;
      if (cif.cmd_ready !== 1'b0) $display("FAIL hex_ready_exec got %b want 0", cif.cmd_ready); else n_pass++;
      step(1);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL hex1a2f_oct%0d got %h want %h", i, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
      end
      send_cmd(3'd6, 16'h0002, acc);
      step(1);
      n_chk++;
      if (oct2 !== {7'h6D, 1'b1}) $display("FAIL dp_oct2 got %h want %h", oct2, {7'h6D, 1'b1}); else n_pass++;
      for (int k = 0; k < 8; k++) begin
         op = ops[$urandom_range(0, 3)];
         d  = 16'($urandom_range(0, 65535));
         send_cmd(op, d, acc);
         step(1);
         n_chk += 2;
         if (ld !== m_ld) $display("FAIL rand_ld op=%0d got %h want %h", op, ld, m_ld); else n_pass++;
         if (cif.cmd_ready !== 1'b1) $display("FAIL rand_ready op=%0d got %b want 1", op, cif.cmd_ready); else n_pass++;
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL rand_oct%0d op=%0d got %h want %h", i, op, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, prev;
      send_cmd(3'd2, 16'($urandom_range(0, 65535)), prev);
      for (int k = 0; k < 5; k++) begin
         send_cmd(3'd2, 16'($urandom_range(0, 65535)), acc);
         n_chk++;
         if (acc - prev !== 2) $display("FAIL b2b_spacing got %0d want 2", acc - prev); else n_pass++;
         prev = acc;
      end
      step(1);
      n_chk++;
      if (ld !== m_ld) $display("FAIL b2b_ld got %h want %h", ld, m_ld); else n_pass++;
   endtask

   task automatic test_beep(input int n);
      int acc, span;
      logic [15:0] d;
      logic exp_buzz, exp_busy, exp_ready, train;
      d = {8'($urandom_range(0, 255)), 8'(n)};
      span = 2 * n * BEEP_CYC;
      send_cmd(3'd3, d, acc);
      for (int j = 0; j <= span + 2; j++) begin
         train     = (j >= 1) && (j <= span);
         exp_buzz  = train && (((j - 1) / BEEP_CYC) % 2 == 0);
         exp_busy  = train;
         exp_ready = (j >= 1) && !train;
         n_chk += 3;
         if (buzz !== exp_buzz) $display("FAIL beep%0d_buzz j=%0d got %b want %b", n, j, buzz, exp_buzz); else n_pass++;
         if (busy !== exp_busy) $display("FAIL beep%0d_busy j=%0d got %b want %b", n, j, busy, exp_busy); else n_pass++;
         if (cif.cmd_ready !== exp_ready) $display("FAIL beep%0d_ready j=%0d got %b want %b", n, j, cif.cmd_ready, exp_ready); else n_pass++;
         step(1);
      end
   endtask

   task automatic test_blink();
      int acc;
      send_cmd(3'd1, 16'h8888, acc);
      send_cmd(3'd2, 16'h00A5, acc);
      send_cmd(3'd4, 16'h0001, acc);
      step(1);
      for (int j = 0; j < 20; j++) begin
         n_chk += 2;
         if (ld !== 8'hA5) $display("FAIL blink_ld t=%0d got %h want a5", cyc, ld); else n_pass++;
         if (oct0 !== exp_oct(0, cyc)) $display("FAIL blink_oct0 t=%0d got %h want %h", cyc, oct0, exp_oct(0, cyc)); else n_pass++;
         for (int i = 1; i < 4; i++) begin
            n_chk++;
            if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL blink_oct%0d t=%0d got %h want %h", i, cyc, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
         end
         step(1);
      end
      send_cmd(3'd1, 16'($urandom_range(0, 65535)), acc);
      step(1);
      for (int j = 0; j < 12; j++) begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL blink_hex_oct%0d t=%0d got %h want %h", i, cyc, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
         end
         step(1);
      end
      send_cmd(3'd4, 16'h0000, acc);
      step(1);
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL blink_off_oct%0d t=%0d got %h want %h", i, cyc, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
         end
         step(1);
      end
   endtask

   task automatic test_err();
      int acc_err, acc_led, rises0, waited;
      logic [15:0] d;
      logic [7:0] ld_before;
      rises0 = buzz_rises;
      send_cmd(3'd7, 16'($urandom_range(0, 65535)), acc_err);
      step(1);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL err_oct%0d got %h want %h", i, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
      end
      // Present an LED command during the train and hold it.
      ld_before = m_ld;
      d = 16'($urandom_range(0, 65535));
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = 3'd2;
      cif.cmd_data  = d;
      waited = 0;
      while (cif.cmd_ready !== 1'b1 && waited < WAIT_MAX) begin step(1); waited++; end
      n_chk += 2;
      if (waited >= WAIT_MAX) $display("FAIL err_wait cmd_ready=%b required 1", cif.cmd_ready); else n_pass++;
      if (ld !== ld_before) $display("FAIL err_held_ld got %h want %h", ld, ld_before); else n_pass++;
      step(1);
      acc_led = cyc;
      cif.cmd_valid = 1'b0;
      model_cmd(3'd2, d, acc_led + 1);
      step(1);
      n_chk += 3;
      if (acc_led !== acc_err + 2 + 6 * BEEP_CYC) $display("FAIL err_accept_edge got %0d want %0d", acc_led, acc_err + 2 + 6 * BEEP_CYC); else n_pass++;
      if (buzz_rises - rises0 !== 3) $display("FAIL err_pulses got %0d want 3", buzz_rises - rises0); else n_pass++;
      if (ld !== m_ld) $display("FAIL err_ld_after got %h want %h", ld, m_ld); else n_pass++;
   endtask

   task automatic test_clear();
      int acc;
      send_cmd(3'd1, 16'($urandom_range(1, 65535)), acc);
      send_cmd(3'd6, 16'h000F, acc);
      send_cmd(3'd4, 16'h0001, acc);
      send_cmd(3'd5, 16'($urandom_range(0, 65535)), acc);
      step(1);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (oct_arr[i] !== 8'h00) $display("FAIL clear_oct%0d got %h want 00", i, oct_arr[i]); else n_pass++;
      end
      // Blinking must stay off after CLEAR.
      send_cmd(3'd1, 16'($urandom_range(0, 65535)), acc);
      step(1);
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (oct_arr[i] !== exp_oct(i, cyc)) $display("FAIL clear_noblink_oct%0d t=%0d got %h want %h", i, cyc, oct_arr[i], exp_oct(i, cyc)); else n_pass++;
         end
         step(1);
      end
   endtask

   task automatic test_reset_mid_beep();
      int acc;
      send_cmd(3'd1, 16'h1234, acc);
      send_cmd(3'd3, 16'h0003, acc);
      step(5);
      n_chk++;
      if (busy !== 1'b1) $display("FAIL midbeep_busy_before got %b want 1", busy); else n_pass++;
      rst = 1'b1;
      step(1);
      n_chk += 4;
      if (buzz !== 1'b0) $display("FAIL midbeep_buzz got %b want 0", buzz); else n_pass++;
      if (busy !== 1'b0) $display("FAIL midbeep_busy got %b want 0", busy); else n_pass++;
      if (cif.cmd_ready !== 1'b1) $display("FAIL midbeep_ready got %b want 1", cif.cmd_ready); else n_pass++;
      if ({oct0, oct1, oct2, oct3} !== 32'h0) $display("FAIL midbeep_oct got %h%h%h%h want 0", oct0, oct1, oct2, oct3); else n_pass++;
      rst = 1'b0;
      model_reset();
      step(1);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = 3'd0;
      cif.cmd_data  = 16'h0;
      model_reset();
      step(1);
      test_reset();
      test_hex_dp();
      test_back_to_back();
      test_beep(2);
      test_beep($urandom_range(1, 3));
      test_beep(0);
      test_beep(255);
      test_blink();
      test_err();
      test_clear();
      test_reset_mid_beep();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t checks=%0d", $time, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/output_controller.md
# output_controller

Command-driven sequencer for the calculator's display/annunciator path. It accepts one-word commands from the calculator core over a valid/ready handshake and maintains the four digit octets feeding the display scanner, the LED bank and the buzzer. It owns hex-to-segment encoding, decimal points, display blinking and timed beep trains, so the core issues fire-and-forget commands.

## Interface
- BEEP_CYC, 5000000: buzzer on-time and off-time per beep, in clock cycles (≥2)
- BLINK_CYC, 12500000: blink half-period in clock cycles (≥2)
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode
- cmd_data  in  16  operand
- oct0, oct1, oct2, oct3  out  [0:7] each  digit segments a,b,c,d,e,f,g,dp, active-high; oct0 = leftmost digit
- LD  out  8  LED bank
- Buzz  out  1  buzzer drive, active-high
- busy  out  1  beep train in progress

## Operation
- Handshake: accept when cmd_valid & cmd_ready at a rising edge; op/data captured at that edge; cmd_ready = (state == IDLE).
- States: IDLE → EXEC on accept. EXEC applies the command for one cycle, then:
  - non-beep ops → IDLE
  - BEEP with N ≠ 0, and ERR → BEEP_ON
  - BEEP with N = 0 → IDLE
- BEEP_ON (Buzz=1) → BEEP_OFF after BEEP_CYC cycles. BEEP_OFF (Buzz=0) → BEEP_ON after BEEP_CYC cycles if beeps remain, else IDLE.
- Opcodes:
  - 0 NOP: no effect.
  - 1 HEX: digit i shows the hex font of cmd_data nibble (oct0 = [15:12] … oct3 = [3:0]); dp bits preserved.
  - 2 LED: LD ← cmd_data[7:0].
  - 3 BEEP: N = cmd_data[7:0] beeps.
  - 4 BLINK: blink_en ← cmd_data[0]; blink counter and phase cleared.
  - 5 CLEAR: all segments and dp bits 0; blink_en ← 0.
  - 6 DP: dp of digit i ← cmd_data[3−i] (oct0 ← bit 3).
  - 7 ERR: digits "E","r","r",blank; dp cleared; 3 beeps.
- Font (a..g): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; r=05.
- Blink: while blink_en, phase toggles every BLINK_CYC cycles. Phase 1 forces all oct outputs to 0. Stored digit state is untouched; LD and Buzz are unaffected.
- busy = state ∈ {BEEP_ON, BEEP_OFF}.

## Timing
- Reset: state IDLE, cmd_ready=1, oct0..3=0, LD=0, Buzz=0, busy=0, blink_en=0, blink phase 0, all counters 0. Reset during a beep train aborts it: Buzz=0 after that edge.
- Command accepted at edge k: display/LED registers update at edge k+1; cmd_ready=0 during cycle k+1 and returns high after edge k+1 for non-beep ops. Peak throughput is one command per 2 cycles.
- BEEP/ERR accepted at edge k: Buzz rises at edge k+1 and stays high exactly BEEP_CYC cycles, then low exactly BEEP_CYC cycles, repeated N times. State returns to IDLE at edge k+1+2·N·BEEP_CYC, with cmd_ready high in that cycle.
- No commands are accepted while busy; cmd_valid is ignored and the pending command is held by the core.
- Blink: the counter runs every cycle while blink_en. The first blank phase starts BLINK_CYC cycles after the BLINK command's EXEC edge. A HEX/DP command during blink updates stored digits without resetting the phase.
- N=255 is a legal beep count; the beep counter is 8-bit with no wrap.

## Test plan
- Reset mid-beep (BEEP_CYC=4, N=3), Reset asserted at cycle 6 → next cycle Buzz=0, busy=0, cmd_ready=1, all oct=0.
- HEX 0x1A2F, then DP 0x2 → oct0=30, oct1=77, oct2=6D, oct3=47 two cycles after accept; then oct2 dp set (oct2=6D|dp).
- BEEP N=2 with BEEP_CYC=4 → Buzz high cycles 1–4 and 9–12 after accept, low otherwise; cmd_ready low for 17 cycles; busy high throughout the train.
- BEEP N=0 → no Buzz pulse; cmd_ready back after 1 cycle.
- BLINK on with BLINK_CYC=3 after HEX 0x8888 → oct alternate 7F and 00 every 3 cycles; LD=0xA5 stays steady; BLINK off → constant 7F.
- ERR → oct = 4F, 05, 05, 00 and 3 Buzz pulses; commands presented during the train are accepted only after busy falls. Back-to-back LED commands → accepted every 2nd cycle.
